seq_pattern_ctrl: RTL
=====================

Name: seq_pattern_ctrl

Overview:
- Programmable stimulus sequencer for the two-input sequence-detector FSMs in this codebase.
- Holds a small table of steps. Each step is an (i2, i1) drive value plus a dwell count in clock cycles.
- On start, plays the table onto i2/i1, then signals completion.
- Watches the detector's match output during the run and records a sticky hit flag. Used both as an on-chip pattern source and as the test sequencer for detector blocks.

Parameters:
- DEPTH, 16, number of table entries (power of 2, at least 2)
- AW, 4, table address width, equal to log2(DEPTH)
- DW, 12, dwell counter width; the maximum dwell is 2^DW-1 cycles

Ports:
- clk  input  1  clock; all logic is on the rising edge
- reset  input  1  synchronous, active-low reset
- cfg_we  input  1  table write strobe
- cfg_addr  input  AW  table write address
- cfg_wdata  input  DW+2  entry: bit DW+1 = i2, bit DW = i1, bits DW-1:0 = dwell
- cfg_len  input  AW+1  number of steps to play; sampled on an accepted start
- start  input  1  level-sampled request to begin a run
- abort  input  1  terminate the current run
- match_in  input  1  match output of the driven detector
- i2  output  1  driven pattern bit 2
- i1  output  1  driven pattern bit 1
- busy  output  1  high while a run is in progress
- done  output  1  one-cycle pulse at normal completion
- hit  output  1  sticky: match_in was seen high during the current or last run
- step_idx  output  AW  index of the step currently being driven

Behaviour:
- Reset (reset==0 at a clock edge):
  - i2=0, i1=0, busy=0, done=0, hit=0, step_idx=0; FSM goes to IDLE; internal counters cleared.
  - Table contents are not reset.
  - Reset overrides every other input. A run in progress is dropped without a done pulse.
- Table write: cfg_we=1 in IDLE writes cfg_wdata to entry cfg_addr on that edge. cfg_we while busy is ignored (write dropped).
- Effective length: L = min(cfg_len, DEPTH). Effective dwell of an entry: D = max(dwell, 1); dwell 0 counts as 1 cycle.
- FSM states: IDLE, RUN.
- IDLE:
  - i2=i1=0, busy=0.
  - start=1 with L>0 at edge T:
    - from cycle T+1: busy=1, step_idx=0, (i2,i1) = entry 0 values;
    - hit cleared to 0; dwell counter loaded with D0-1; L latched; go to RUN.
  - start=1 with L==0: done=1 for the single cycle T+1, hit cleared, busy stays 0, stays IDLE.
- RUN, each edge:
  - abort=1 (highest priority after reset): next cycle IDLE, i2=i1=0, busy=0, no done pulse, hit keeps its value.
  - else if count!=0: decrement count; outputs unchanged.
  - else if step_idx==L-1: next cycle i2=i1=0, busy=0, done=1 for exactly one cycle, go to IDLE.
  - else: step_idx+1, drive the next entry's bits, count = D-1.
- Step timing:
  - Each step is driven for exactly D cycles. Total busy cycles = sum of D over steps 0..L-1.
  - done rises in the cycle busy falls.
  - Table writes are blocked while busy, so the table is stable for the whole run.
- start while busy is ignored. start held high through completion starts a new run on the edge after done (back-to-back runs allowed).
- hit:
  - Set on any edge where busy==1 and match_in==1, including the final step's last cycle.
  - Cleared only by reset or an accepted start.
  - match_in while idle is ignored.
- abort in IDLE has no effect. abort and start together in IDLE: start wins.

Test Plan:
- DEPTH=16, DW=12; write e0=(i2=1,i1=0,dwell 5), e1=(0,0,3), e2=(0,1,0), e3=(1,1,2); start with cfg_len=4 -> busy for 11 cycles; (i2,i1) = 10 for 5 cycles, 00 for 3, 01 for 1, 11 for 2; step_idx 0,1,2,3; done pulses once in the cycle busy falls; outputs return to 00.
- Same table; pulse match_in for 1 cycle during step 1 -> hit=1 after run and stays 1; issue a new start -> hit=0 on the first busy cycle.
- Start with cfg_len=4, assert abort during step 1 -> next cycle busy=0, i2=i1=0, no done pulse; then a cfg_we to entry 0 succeeds.
- While busy: issue cfg_we to entry 1 and a second start -> table unchanged (readback via rerun shows original 00 for 3 cycles); no restart.
- cfg_len=0 start -> single done pulse, busy never asserts. cfg_len=20 -> plays all 16 entries, then done.
- Drive reset=0 mid-run at step 2 -> next cycle all outputs 0, IDLE. After reset is released, start with cfg_len=4 replays the retained table identically.

Source files
------------

// File: rtl/seq_pattern_ctrl.sv
// Programmable (i2, i1) stimulus sequencer: plays a table of (bits, dwell) steps
// onto a detector's inputs and records whether its match output fired.
module seq_pattern_ctrl #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned DW    = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [DW+1:0] cfg_wdata,
  input  logic [AW:0]   cfg_len,
  input  logic          start,
  input  logic          abort,
  input  logic          match_in,
  output logic          i2,
  output logic          i1,
  output logic          busy,
  output logic          done,
  output logic          hit,
  output logic [AW-1:0] step_idx
);

  localparam int unsigned EW = DW + 2;
  localparam int unsigned LW = AW + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic          i2_q, i2_d;
  logic          i1_q, i1_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          hit_q, hit_d;
  logic [AW-1:0] step_q, step_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] len_q, len_d;

  logic [EW-1:0] tbl_q [DEPTH];

  logic [LW-1:0] eff_len_c;
  logic [EW-1:0] first_c;
  logic [EW-1:0] next_c;
  logic          last_step_c;

  // A programmed dwell of zero still occupies one cycle.
  function automatic logic [DW-1:0] dwell_m1(input logic [DW-1:0] dw);
    return (dw == '0) ? '0 : dw - DW'(1);
  endfunction

  assign eff_len_c   = (cfg_len > LW'(DEPTH)) ? LW'(DEPTH) : cfg_len;
  assign first_c     = tbl_q[0];
  assign next_c      = tbl_q[step_q + AW'(1)];
  assign last_step_c = ({1'b0, step_q} == (len_q - LW'(1)));

  // Table is writable only while idle so a run always sees a stable table.
  always_ff @(posedge clk) begin
    if (reset && cfg_we && (state_q == IDLE)) begin
      tbl_q[cfg_addr] <= cfg_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      i2_q    <= 1'b0;
      i1_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hit_q   <= 1'b0;
      step_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      i2_q    <= i2_d;
      i1_q    <= i1_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hit_q   <= hit_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    i2_d    = i2_q;
    i1_d    = i1_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hit_d   = hit_q | (busy_q & match_in);
    step_d  = step_q;
    cnt_d   = cnt_q;
    len_d   = len_q;

    case (state_q)
      IDLE: begin
        i2_d   = 1'b0;
        i1_d   = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          hit_d = 1'b0;
          if (eff_len_c != '0) begin
            state_d = RUN;
            busy_d  = 1'b1;
            step_d  = '0;
            i2_d    = first_c[DW+1];
            i1_d    = first_c[DW];
            cnt_d   = dwell_m1(first_c[DW-1:0]);
            len_d   = eff_len_c;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      RUN: begin
        if (abort) begin
          state_d = IDLE;
          i2_d    = 1'b0;
          i1_d    = 1'b0;
          busy_d  = 1'b0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DW'(1);
        end else if (last_step_c) begin
          state_d = IDLE;
          i2_d    = 1'b0;
          i1_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          step_d = step_q + AW'(1);
          i2_d   = next_c[DW+1];
          i1_d   = next_c[DW];
          cnt_d  = dwell_m1(next_c[DW-1:0]);
        end
      end

      default: begin
        state_d = IDLE;
        i2_d    = 1'b0;
        i1_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign i2       = i2_q;
  assign i1       = i1_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign hit      = hit_q;
  assign step_idx = step_q;

endmodule
